// File: rtl/glitch_cmd_decoder.sv
// Host command front end: parses the uart_rx byte stream into glitch config registers,
// control strobes and length-prefixed passthrough frames. Optional feature: CMD_TIMEOUT_EN.
module glitch_cmd_decoder #(
  parameter int unsigned WIDTH_W          = 8,
  parameter int unsigned COUNT_W          = 8,
  parameter int unsigned DELAY_BYTES      = 4,
  parameter int unsigned BOARD_RST_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES   = 1200000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic [7:0]               pt_data,
  output logic                     pt_valid,
  input  logic                     pt_rdy,
  output logic [WIDTH_W-1:0]       o_width,
  output logic [COUNT_W-1:0]       o_count,
  output logic [8*DELAY_BYTES-1:0] o_delay,
  output logic                     o_sys_rst,
  output logic                     o_board_rst,
  output logic                     o_glitch_arm,
  output logic                     o_err
);

  localparam int unsigned DELAY_W = 8 * DELAY_BYTES;
  localparam int unsigned BRST_W  = $clog2(BOARD_RST_CYCLES + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PASS = 2'd1;
  localparam logic [1:0] ESC  = 2'd2;
  localparam logic [1:0] ARG  = 2'd3;

  localparam logic [1:0] SEL_WIDTH = 2'd0;
  localparam logic [1:0] SEL_COUNT = 2'd1;
  localparam logic [1:0] SEL_DELAY = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [7:0]         remain_q, remain_d;
  logic [1:0]         sel_q, sel_d;
  logic [2:0]         dbyte_q, dbyte_d;
  logic [BRST_W-1:0]  brst_cnt_q, brst_cnt_d;
  logic [WIDTH_W-1:0] width_d;
  logic [COUNT_W-1:0] count_d;
  logic [DELAY_W-1:0] delay_d;
  logic [7:0]         pt_data_d;
  logic               pt_valid_d, err_d, sys_rst_d, arm_d;
  logic               timeout_c;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt_q;

  // Inter-byte silence counter, only meaningful mid-command or mid-frame
  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE || in_valid || timeout_c) idle_cnt_q <= '0;
    else                                                 idle_cnt_q <= idle_cnt_q + TO_W'(1);
  end

  assign timeout_c = (state_q != IDLE) && !in_valid &&
                     (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      remain_q     <= '0;
      sel_q        <= SEL_WIDTH;
      dbyte_q      <= '0;
      brst_cnt_q   <= '0;
      o_width      <= WIDTH_W'(1);
      o_count      <= '0;
      o_delay      <= '0;
      pt_data      <= '0;
      pt_valid     <= 1'b0;
      o_err        <= 1'b0;
      o_sys_rst    <= 1'b0;
      o_glitch_arm <= 1'b0;
      o_board_rst  <= 1'b0;
    end else begin
      state_q      <= state_d;
      remain_q     <= remain_d;
      sel_q        <= sel_d;
      dbyte_q      <= dbyte_d;
      brst_cnt_q   <= brst_cnt_d;
      o_width      <= width_d;
      o_count      <= count_d;
      o_delay      <= delay_d;
      pt_data      <= pt_data_d;
      pt_valid     <= pt_valid_d;
      o_err        <= err_d;
      o_sys_rst    <= sys_rst_d;
      o_glitch_arm <= arm_d;
      o_board_rst  <= (brst_cnt_d != '0);
    end
  end

  // Next-state and register-update decode
  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    sel_d      = sel_q;
    dbyte_d    = dbyte_q;
    width_d    = o_width;
    count_d    = o_count;
    delay_d    = o_delay;
    pt_data_d  = pt_data;
    pt_valid_d = pt_valid & ~pt_rdy;
    err_d      = o_err;
    sys_rst_d  = 1'b0;
    arm_d      = 1'b0;
    brst_cnt_d = (brst_cnt_q != '0) ? brst_cnt_q - BRST_W'(1) : brst_cnt_q;

    if (timeout_c) begin
      state_d = IDLE;
    end else if (in_valid) begin
      case (state_q)
        IDLE: begin
          if (in_data == 8'h00) state_d = ESC;
          else begin
            state_d  = PASS;
            remain_d = in_data;
          end
        end
        PASS: begin
          // A byte arriving on the handshake cycle finds the hold register free
          if (pt_valid && !pt_rdy) begin
            err_d = 1'b1;
          end else begin
            pt_data_d  = in_data;
            pt_valid_d = 1'b1;
          end
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) state_d = IDLE;
        end
        ESC: begin
          state_d = IDLE;
          case (in_data)
            8'hFF: sys_rst_d  = 1'b1;
            8'hFE: brst_cnt_d = BRST_W'(BOARD_RST_CYCLES);
            8'hFC: arm_d      = 1'b1;
            8'h10: begin
              state_d = ARG;
              sel_d   = SEL_WIDTH;
            end
            8'h11: begin
              state_d = ARG;
              sel_d   = SEL_COUNT;
            end
            default: begin
              if (in_data[7:3] == 5'b00100 && 32'(in_data[2:0]) < DELAY_BYTES) begin
                state_d = ARG;
                sel_d   = SEL_DELAY;
                dbyte_d = in_data[2:0];
              end else begin
                err_d = 1'b1;
              end
            end
          endcase
        end
        ARG: begin
          state_d = IDLE;
          case (sel_q)
            SEL_WIDTH: width_d = WIDTH_W'(in_data);
            SEL_COUNT: count_d = COUNT_W'(in_data);
            SEL_DELAY: begin
              for (int k = 0; k < int'(DELAY_BYTES); k++) begin
                if (dbyte_q == 3'(k)) delay_d[8*k +: 8] = in_data;
              end
            end
            default: ;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
